alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Operand-fetch stage that feeds `alu16`: an 8 × 16-bit register file, an issue port, and a one-entry pipeline register. It takes an instruction's source/destination register indices and the 3-bit ALU opcode, reads both operands, and holds them in registered outputs for the ALU under a valid/ready handshake. The ALU result returns through the write-back port, closing the datapath loop.

## Interface
- `NREG`, 8: number of architectural registers; R0 reads as zero.
- `W`, 16: data width, matching `alu16`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in_valid` in 1: issue request present.
- `in_ready` out 1: stage can accept an issue this cycle.
- `in_rs` in 3: source register A index.
- `in_rt` in 3: source register B index.
- `in_rd` in 3: destination index, passed through.
- `in_alu_op` in 3: ALU opcode, passed through.
- `out_valid` out 1: operand bundle valid.
- `out_ready` in 1: ALU consumes the bundle.
- `out_a` out 16: operand A to `alu16`.
- `out_b` out 16: operand B to `alu16`.
- `out_alu_op` out 3: latched opcode.
- `out_rd` out 3: latched destination.
- `wb_en` in 1: write-back enable.
- `wb_addr` in 3: write-back register.
- `wb_data` in 16: write-back value (the ALU `s`).

## Operation
- Register file: `NREG` × `W` flops.
  - Write is synchronous: on the edge with `wb_en=1` and `wb_addr≠0`, `reg[wb_addr] <= wb_data`.
  - Writes to R0 are discarded.
  - Reads are combinational from `in_rs` and `in_rt`; index 0 returns 0x0000.
- Handshake:
  - `in_ready = !out_valid || out_ready`.
  - An issue is accepted when `in_valid && in_ready`.
  - The output bundle transfers when `out_valid && out_ready`.
- On accept: `out_a`, `out_b`, `out_alu_op` and `out_rd` load the read values and pass-through fields; `out_valid` is set to 1.
- Transfer without an accept in the same cycle: `out_valid` is cleared to 0. Data outputs hold their last values.
- Transfer and accept in the same cycle: the new bundle replaces the old one, and `out_valid` stays at 1. Full throughput is one bundle per cycle.
- Stall (`out_valid=1`, `out_ready=0`):
  - All `out_*` outputs hold stable.
  - `in_ready=0`.
  - Write-back continues, but it does not alter a bundle that is already captured.
- Operands are captured at accept time only. They are never refreshed while held.

## Timing
- Reset state: every register = 0x0000, `out_valid=0`, `out_a=out_b=0x0000`, `out_alu_op=3'b000`, `out_rd=3'b000`. `in_ready=1` as soon as reset is asserted.
- Reset asserted mid-operation discards a pending bundle and any write-back on that edge. The first accept is possible on the first rising edge after `reset` deasserts.
- Latency is 1 cycle: an issue accepted at edge N is presented with `out_valid=1` after edge N.
- Write-back to register file visibility: a value written at edge N is readable from combinational reads after edge N.
- Same-edge write-back and accept on a matching register: governed by `OPERAND_BYPASS_EN` (see Configuration).
- `wb_addr=0` together with a matching `in_rs=0` or `in_rt=0`: the operand is always 0x0000, including under bypass.

## Configuration
- `OPERAND_BYPASS_EN` defined:
  - On an accept edge with `wb_en=1`, `wb_addr≠0` and `wb_addr==in_rs` (or `in_rt`), the captured operand is `wb_data`.
  - Back-to-back dependent ALU ops therefore need no bubble.
- `OPERAND_BYPASS_EN` undefined:
  - The captured operand is the pre-write register value.
  - Hazard avoidance is the issuing logic's responsibility.
  - No bypass comparators are instantiated.

## Test plan
- Reset, then write-back: R1=0x0014, R2=0x0013; issue rs=1, rt=2, op=3'b010, rd=3 with `out_ready=1`.
  - Next cycle: `out_a=0x0014`, `out_b=0x0013`, `out_alu_op=3'b010`, `out_rd=3`, `out_valid=1`.
- R0 checks: write-back to R0 with 0xFFFF, then issue rs=0, rt=0.
  - Required: `out_a=out_b=0x0000`.
- Stall: hold `out_ready=0` for 3 cycles after an accept, while `in_valid=1` and a write-back of 0xAAAA targets R1.
  - Required: `in_ready=0`; `out_a` stays 0x0014; no second accept.
  - Release `out_ready`: next issue accepted the same cycle.
- Throughput: 4 issues back-to-back with `out_ready=1`.
  - Required: `out_valid` continuously 1 for 4 cycles; bundles in order.
- Bypass: same-edge write-back of R1=0x1234 and issue rs=1.
  - With `OPERAND_BYPASS_EN`: `out_a=0x1234`.
  - Without: `out_a=0x0014`, then 0x1234 on the following issue.
- Async reset: assert `reset` mid-cycle while `out_valid=1`.
  - Required: `out_valid`, `out_a` and all registers clear immediately, before the next edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand-fetch stage in front of alu16.
//   Holds an NREG x W register file (R0 reads as zero) and a one-entry
//   pipeline register. Each accepted issue captures both source operands,
//   the opcode and the destination index. The bundle is then held for the
//   ALU under a valid/ready handshake. ALU results return on the wb_* port.
//
// Optional feature (compile-time macro OPERAND_BYPASS_EN):
//   When defined, a write-back on the accept edge forwards into the
//   captured operand if its index matches (never for R0).
//   When undefined, no forwarding comparators exist. The captured operand
//   is then the pre-write register value.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   in_valid / in_ready      issue handshake (in_ready is combinational)
//   in_rs, in_rt, in_rd      source A/B and destination register indices
//   in_alu_op                ALU opcode, passed through
//   out_valid / out_ready    operand-bundle handshake
//   out_a, out_b             registered operands for alu16
//   out_alu_op, out_rd       registered opcode and destination
//   wb_en, wb_addr, wb_data  register-file write-back port
module alu_operand_stage #(
  parameter int unsigned NREG = 8,
  parameter int unsigned W    = 16,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic [2:0]    in_alu_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b,
  output logic [2:0]    out_alu_op,
  output logic [AW-1:0] out_rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data
);

  logic [W-1:0]  r_regs [NREG];
  logic          r_out_valid;
  logic [W-1:0]  r_out_a;
  logic [W-1:0]  r_out_b;
  logic [2:0]    r_out_alu_op;
  logic [AW-1:0] r_out_rd;

  logic          w_accept;
  logic          w_wb_write;
  logic [W-1:0]  w_rd_a;
  logic [W-1:0]  w_rd_b;
  logic [W-1:0]  w_op_a;
  logic [W-1:0]  w_op_b;

  // Write-back qualified: R0 is never written.
  assign w_wb_write = wb_en && (wb_addr != '0);

  // Register file write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wb_write) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Combinational reads; index 0 forced to zero.
  assign w_rd_a = (in_rs == '0) ? '0 : r_regs[in_rs];
  assign w_rd_b = (in_rt == '0) ? '0 : r_regs[in_rt];

`ifdef OPERAND_BYPASS_EN
  // Forward a same-edge write-back. w_wb_write already excludes R0.
  assign w_op_a = (w_wb_write && (wb_addr == in_rs)) ? wb_data : w_rd_a;
  assign w_op_b = (w_wb_write && (wb_addr == in_rt)) ? wb_data : w_rd_b;
`else
  assign w_op_a = w_rd_a;
  assign w_op_b = w_rd_b;
`endif

  // Handshake: a held bundle frees the slot when it transfers this cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Pipeline register: operands captured on accept only, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_out_alu_op <= 3'b000;
      r_out_rd     <= '0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_a      <= w_op_a;
      r_out_b      <= w_op_b;
      r_out_alu_op <= in_alu_op;
      r_out_rd     <= in_rd;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_a      = r_out_a;
  assign out_b      = r_out_b;
  assign out_alu_op = r_out_alu_op;
  assign out_rd     = r_out_rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: issues push hand-computed bundles,
// a negedge monitor pops and compares each bundle as it transfers.
module tb_alu_operand_stage;

`ifdef OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [2:0]  rd;
  } bundle_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_rs, in_rt, in_rd, in_alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a, out_b;
  logic [2:0]  out_alu_op, out_rd;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  bundle_t sb[$];
  bundle_t exp_b;

  alu_operand_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_alu_op(in_alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op), .out_rd(out_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every transferring bundle against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_bundle: got a=0x%0h b=0x%0h expected none", out_a, out_b);
      end else begin
        exp_b = sb.pop_front();
        check("out_a",      32'(out_a),      32'(exp_b.a));
        check("out_b",      32'(out_b),      32'(exp_b.b));
        check("out_alu_op", 32'(out_alu_op), 32'(exp_b.op));
        check("out_rd",     32'(out_rd),     32'(exp_b.rd));
        n_xfer++;
      end
    end
  end

  // Called at posedge+1; drives for one edge.
  task automatic wb_write(input logic [2:0] addr, input logic [15:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue one instruction; it must be accepted on the first edge.
  task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] op,
                       input logic [2:0] rd, input logic [15:0] ea, input logic [15:0] eb,
                       input bit chk_valid);
    bundle_t e;
    in_valid = 1'b1; in_rs = rs; in_rt = rt; in_alu_op = op; in_rd = rd;
    @(negedge clk);
    check("in_ready_at_issue", 32'(in_ready), 32'd1);
    if (chk_valid) check("out_valid_continuous", 32'(out_valid), 32'd1);
    if (in_ready) begin
      e.a = ea; e.b = eb; e.op = op; e.rd = rd;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_alu_op = '0;
    out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    // Reset state
    #3;
    check("reset_in_ready",   32'(in_ready),   32'd1);
    check("reset_out_valid",  32'(out_valid),  32'd0);
    check("reset_out_a",      32'(out_a),      32'd0);
    check("reset_out_b",      32'(out_b),      32'd0);
    check("reset_out_alu_op", 32'(out_alu_op), 32'd0);
    check("reset_out_rd",     32'(out_rd),     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic issue after write-back
    wb_write(3'd1, 16'h0014);
    wb_write(3'd2, 16'h0013);
    issue(3'd1, 3'd2, 3'b010, 3'd3, 16'h0014, 16'h0013, 1'b0);

    // R0: write discarded; same-edge R0 write never forwards
    wb_write(3'd0, 16'hFFFF);
    issue(3'd0, 3'd0, 3'b001, 3'd0, 16'h0000, 16'h0000, 1'b0);
    wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
    issue(3'd0, 3'd0, 3'b011, 3'd1, 16'h0000, 16'h0000, 1'b0);
    wb_en = 1'b0;
    idle(1);

    // Stall: bundle held, issue blocked, write-back continues
    out_ready = 1'b0;
    issue(3'd1, 3'd2, 3'b001, 3'd4, 16'h0014, 16'h0013, 1'b0);
    in_valid = 1'b1; in_rs = 3'd1; in_rt = 3'd1; in_alu_op = 3'b101; in_rd = 3'd6;
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_a",     32'(out_a),     32'h0014);
      check("stall_out_rd",    32'(out_rd),    32'd4);
      @(posedge clk); #1;
      wb_en = 1'b0;
    end
    out_ready = 1'b1;
    issue(3'd1, 3'd1, 3'b101, 3'd6, 16'hAAAA, 16'hAAAA, 1'b1);

    // Throughput: four back-to-back issues, valid must stay high
    issue(3'd1, 3'd2, 3'b000, 3'd1, 16'hAAAA, 16'h0013, 1'b1);
    issue(3'd2, 3'd1, 3'b001, 3'd2, 16'h0013, 16'hAAAA, 1'b1);
    issue(3'd0, 3'd2, 3'b011, 3'd3, 16'h0000, 16'h0013, 1'b1);
    issue(3'd1, 3'd0, 3'b111, 3'd7, 16'hAAAA, 16'h0000, 1'b1);
    @(negedge clk);
    check("throughput_last_valid", 32'(out_valid), 32'd1);
    idle(1);

    // Same-edge write-back and issue
    wb_write(3'd1, 16'h0014);
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h1234;
    issue(3'd1, 3'd2, 3'b010, 3'd3, BYP ? 16'h1234 : 16'h0014, 16'h0013, 1'b0);
    wb_en = 1'b0;
    issue(3'd1, 3'd0, 3'b010, 3'd3, 16'h1234, 16'h0000, 1'b1);
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h5678;
    issue(3'd0, 3'd2, 3'b100, 3'd5, 16'h0000, BYP ? 16'h5678 : 16'h0013, 1'b1);
    wb_en = 1'b0;
    idle(1);

    // Async reset mid-cycle with a held bundle
    out_ready = 1'b0;
    issue(3'd1, 3'd2, 3'b100, 3'd5, 16'h1234, 16'h5678, 1'b0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_a",     32'(out_a),     32'd0);
    check("async_out_rd",    32'(out_rd),    32'd0);
    check("async_in_ready",  32'(in_ready),  32'd1);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    issue(3'd1, 3'd2, 3'b110, 3'd2, 16'h0000, 16'h0000, 1'b0);
    idle(2);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("transfer_count",   32'(n_xfer),    32'd13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
